level_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 15 +
 rtl/level_ctrl_if.sv | 28 ++
 rtl/pause_timer.sv | 27 ++
 rtl/level_ctrl.sv | 137 +++++++++++++
 tb/tb_level_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the game-progression logic.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        CLEAR = 3'd2,
        OVER  = 3'd3,
        WON   = 3'd4
    } level_state_t;

    localparam int LEVEL_W     = 4;
    localparam int ENEMY_CNT_W = 8;

endpackage

// File: rtl/level_ctrl_if.sv
// Event inputs and status outputs of level_ctrl.
// master = game glue driving events; slave = level_ctrl.
interface level_ctrl_if;
    import game_pkg::*;

    logic                   start;
    logic                   kill;
    logic                   player_dead;
    logic [LEVEL_W-1:0]     level;
    logic [ENEMY_CNT_W-1:0] enemies_left;
    logic [1:0]             lives;
    logic                   playing;
    logic                   paused;
    logic                   level_up;
    logic                   game_over;
    logic                   game_won;

    modport master (
        output start, kill, player_dead,
        input  level, enemies_left, lives, playing, paused, level_up, game_over, game_won
    );

    modport slave (
        input  start, kill, player_dead,
        output level, enemies_left, lives, playing, paused, level_up, game_over, game_won
    );

endinterface

// File: rtl/pause_timer.sv
// Between-level pause timer: counts 0..DELAY-1 while en is high and pulses
// done on the terminal count; held at zero whenever en is low.
module pause_timer #(
    parameter int DELAY = 1
) (
    input  logic pclk,
    input  logic rst,
    input  logic en,
    output logic done
);
    localparam int CNT_W = $clog2(DELAY + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done = en && (cnt_q == CNT_W'(DELAY - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en || done) cnt_d = '0;
    end

    always_ff @(posedge pclk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/level_ctrl.sv
// Game-progression controller: counts kills, pauses between levels, advances
// level and flags game over / won. Optional lives support: LEVEL_CTRL_LIVES_EN.
module level_ctrl
    import game_pkg::*;
#(
    parameter int ENEMIES_PER_LEVEL = 8,
    parameter int MAX_LEVEL         = 2,
    parameter int CLEAR_DELAY       = 65_000_000,
    parameter int LIVES             = 3
) (
    input logic          pclk,
    input logic          rst,
    level_ctrl_if.slave  bus
);
    localparam logic [LEVEL_W-1:0]     LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
    localparam logic [ENEMY_CNT_W-1:0] ENEMY_LOAD = ENEMY_CNT_W'(ENEMIES_PER_LEVEL);
`ifdef LEVEL_CTRL_LIVES_EN
    localparam logic [1:0]             LIVES_LOAD = 2'(LIVES);
`else
    localparam logic [1:0]             LIVES_LOAD = 2'd1;
    logic lives_param_unused;
    assign lives_param_unused = |LIVES;
`endif

    level_state_t           state_q, state_d;
    logic [LEVEL_W-1:0]     level_q, level_d;
    logic [ENEMY_CNT_W-1:0] enemies_left_q, enemies_left_d;
    logic [1:0]             lives_q, lives_d;
    logic                   playing_q, playing_d;
    logic                   paused_q, paused_d;
    logic                   level_up_q, level_up_d;
    logic                   game_over_q, game_over_d;
    logic                   game_won_q, game_won_d;
    logic                   pause_done;

    pause_timer #(.DELAY(CLEAR_DELAY)) u_pause_timer (
        .pclk (pclk),
        .rst  (rst),
        .en   (state_q == CLEAR),
        .done (pause_done)
    );

    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        enemies_left_d = enemies_left_q;
        lives_d        = lives_q;
        level_up_d     = 1'b0;

        case (state_q)
            IDLE: begin
                level_d        = LEVEL_W'(1);
                enemies_left_d = ENEMY_LOAD;
                lives_d        = LIVES_LOAD;
                if (bus.start) state_d = PLAY;
            end
            PLAY: begin
                // A death in the same cycle as a kill wins; the kill is dropped.
                if (bus.player_dead) begin
`ifdef LEVEL_CTRL_LIVES_EN
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                    end else begin
                        lives_d = 2'd0;
                        state_d = OVER;
                    end
`else
                    state_d = OVER;
`endif
                end else if (bus.kill) begin
                    if (enemies_left_q > ENEMY_CNT_W'(1)) begin
                        enemies_left_d = enemies_left_q - ENEMY_CNT_W'(1);
                    end else begin
                        enemies_left_d = '0;
                        state_d        = (level_q >= LEVEL_MAX) ? WON : CLEAR;
                    end
                end
            end
            CLEAR: begin
                if (pause_done) begin
                    if (level_q < LEVEL_MAX) level_d = level_q + LEVEL_W'(1);
                    level_up_d     = 1'b1;
                    enemies_left_d = ENEMY_LOAD;
                    state_d        = PLAY;
                end
            end
            OVER, WON: begin
                if (bus.start) begin
                    level_d        = LEVEL_W'(1);
                    enemies_left_d = ENEMY_LOAD;
                    lives_d        = LIVES_LOAD;
                    state_d        = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase

        playing_d   = (state_d == PLAY);
        paused_d    = (state_d == CLEAR);
        game_over_d = (state_d == OVER);
        game_won_d  = (state_d == WON);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q        <= IDLE;
            level_q        <= LEVEL_W'(1);
            enemies_left_q <= ENEMY_LOAD;
            lives_q        <= LIVES_LOAD;
            playing_q      <= 1'b0;
            paused_q       <= 1'b0;
            level_up_q     <= 1'b0;
            game_over_q    <= 1'b0;
            game_won_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            enemies_left_q <= enemies_left_d;
            lives_q        <= lives_d;
            playing_q      <= playing_d;
            paused_q       <= paused_d;
            level_up_q     <= level_up_d;
            game_over_q    <= game_over_d;
            game_won_q     <= game_won_d;
        end
    end

    assign bus.level        = level_q;
    assign bus.enemies_left = enemies_left_q;
    assign bus.lives        = lives_q;
    assign bus.playing      = playing_q;
    assign bus.paused       = paused_q;
    assign bus.level_up     = level_up_q;
    assign bus.game_over    = game_over_q;
    assign bus.game_won     = game_won_q;

endmodule

// File: tb/tb_level_ctrl.sv
// Directed bench for level_ctrl (ENEMIES=3, MAX_LEVEL=2, CLEAR_DELAY=4, LIVES=2).
module tb_level_ctrl;
    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    level_ctrl_if bus();

    level_ctrl #(
        .ENEMIES_PER_LEVEL (3),
        .MAX_LEVEL         (2),
        .CLEAR_DELAY       (4),
        .LIVES             (2)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

`ifdef LEVEL_CTRL_LIVES_EN
    localparam int EXP_LIVES = 2;
`else
    localparam int EXP_LIVES = 1;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_kill();
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic flags(input string tag, input int pl, input int pa, input int lu,
                         input int go, input int gw);
        chk({tag, ".playing"},   32'(bus.playing),   32'(pl));
        chk({tag, ".paused"},    32'(bus.paused),    32'(pa));
        chk({tag, ".level_up"},  32'(bus.level_up),  32'(lu));
        chk({tag, ".game_over"}, 32'(bus.game_over), 32'(go));
        chk({tag, ".game_won"},  32'(bus.game_won),  32'(gw));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.kill = 1'b0;
        bus.player_dead = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst.level", 32'(bus.level), 1);
        chk("rst.enemies", 32'(bus.enemies_left), 3);
        chk("rst.lives", 32'(bus.lives), EXP_LIVES);
        flags("rst", 0, 0, 0, 0, 0);

        pulse_start();
        chk("start.level", 32'(bus.level), 1);
        chk("start.enemies", 32'(bus.enemies_left), 3);
        flags("start", 1, 0, 0, 0, 0);

        pulse_kill();
        chk("k1.enemies", 32'(bus.enemies_left), 2);
        pulse_kill();
        chk("k2.enemies", 32'(bus.enemies_left), 1);
        pulse_kill();
        chk("k3.enemies", 32'(bus.enemies_left), 0);
        flags("pause1", 0, 1, 0, 0, 0);

        // kill during the pause must be ignored and not stretch it
        pulse_kill();
        chk("pause2.enemies", 32'(bus.enemies_left), 0);
        flags("pause2", 0, 1, 0, 0, 0);
        tick();
        flags("pause3", 0, 1, 0, 0, 0);
        tick();
        flags("pause4", 0, 1, 0, 0, 0);
        chk("pause4.level", 32'(bus.level), 1);
        tick();
        flags("lvl2", 1, 0, 1, 0, 0);
        chk("lvl2.level", 32'(bus.level), 2);
        chk("lvl2.enemies", 32'(bus.enemies_left), 3);
        tick();
        chk("lvl2.level_up_drop", 32'(bus.level_up), 0);

        pulse_kill();
        pulse_kill();
        pulse_kill();
        flags("won", 0, 0, 0, 0, 1);
        chk("won.level", 32'(bus.level), 2);
        chk("won.enemies", 32'(bus.enemies_left), 0);
        pulse_kill();
        chk("won.extra_kill", 32'(bus.enemies_left), 0);
        chk("won.hold", 32'(bus.game_won), 1);

        pulse_start();
        flags("restart", 1, 0, 0, 0, 0);
        chk("restart.level", 32'(bus.level), 1);
        chk("restart.enemies", 32'(bus.enemies_left), 3);
        chk("restart.lives", 32'(bus.lives), EXP_LIVES);

        pulse_kill();
        pulse_kill();
        bus.kill = 1'b1;
        bus.player_dead = 1'b1;
        tick();
        bus.kill = 1'b0;
        bus.player_dead = 1'b0;
        chk("dead.enemies", 32'(bus.enemies_left), 1);
`ifdef LEVEL_CTRL_LIVES_EN
        chk("dead.lives", 32'(bus.lives), 1);
        flags("dead", 1, 0, 0, 0, 0);
        bus.player_dead = 1'b1;
        tick();
        bus.player_dead = 1'b0;
        chk("dead2.lives", 32'(bus.lives), 0);
        flags("dead2", 0, 0, 0, 1, 0);
`else
        chk("dead.lives", 32'(bus.lives), 1);
        flags("dead", 0, 0, 0, 1, 0);
`endif
        pulse_start();
        flags("restart2", 1, 0, 0, 0, 0);
        chk("restart2.enemies", 32'(bus.enemies_left), 3);
        chk("restart2.lives", 32'(bus.lives), EXP_LIVES);

        pulse_kill();
        pulse_kill();
        pulse_kill();
        flags("rp1", 0, 1, 0, 0, 0);
        tick();
        flags("rp2", 0, 1, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        flags("midrst", 0, 0, 0, 0, 0);
        chk("midrst.level", 32'(bus.level), 1);
        chk("midrst.enemies", 32'(bus.enemies_left), 3);

        // pause after a mid-pause reset must again be a full 4 cycles
        pulse_start();
        pulse_kill();
        pulse_kill();
        pulse_kill();
        flags("np1", 0, 1, 0, 0, 0);
        tick();
        tick();
        tick();
        flags("np4", 0, 1, 0, 0, 0);
        tick();
        flags("np_end", 1, 0, 1, 0, 0);
        chk("np_end.level", 32'(bus.level), 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
